// File: rtl/pc_seq_pkg.sv
// Shared types and default constants for the program-counter / return-stack stage.
package pc_seq_pkg;

  localparam int unsigned PC_W_DEF        = 10;
  localparam int unsigned STACK_DEPTH_DEF = 16;
  localparam logic [9:0]  ISR1_ADDR_DEF   = 10'h3F0;
  localparam logic [9:0]  ISR2_ADDR_DEF   = 10'h3F8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISR      = 2'd1,
    ISR_NEST = 2'd2
  } state_t;

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address LIFO: synchronous write, asynchronous read of the top entry.
// Pop takes precedence over push; blocked operations raise err_ovf / err_unf.
module ret_stack #(
  parameter  int unsigned DW    = 10,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned SPW   = AW + 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           i_push,
  input  logic           i_pop,
  input  logic [DW-1:0]  i_wdata,
  output logic [DW-1:0]  o_top,
  output logic [SPW-1:0] o_sp,
  output logic           o_full,
  output logic           o_empty,
  output logic           o_err_ovf,
  output logic           o_err_unf
);

  logic [DW-1:0]  r_mem [DEPTH];
  logic [SPW-1:0] r_sp;
  logic [AW-1:0]  w_top_idx;
  logic           w_full;
  logic           w_empty;
  logic           w_do_push;
  logic           w_do_pop;

  assign w_full    = (r_sp == SPW'(DEPTH));
  assign w_empty   = (r_sp == '0);
  assign w_do_pop  = i_pop & ~w_empty;
  assign w_do_push = i_push & ~i_pop & ~w_full;
  assign w_top_idx = r_sp[AW-1:0] - AW'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sp <= '0;
    end else if (w_do_pop) begin
      r_sp <= r_sp - SPW'(1);
    end else if (w_do_push) begin
      r_sp <= r_sp + SPW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_sp[AW-1:0]] <= i_wdata;
    end
  end

  assign o_top     = r_mem[w_top_idx];
  assign o_sp      = r_sp;
  assign o_full    = w_full;
  assign o_empty   = w_empty;
  assign o_err_ovf = i_push & w_full;
  assign o_err_unf = i_pop & w_empty;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with return stack and edge-latched vectored interrupts.
// Optional macro NESTED_INTR_EN lets intr1 preempt an ISR entered from intr2.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned       PC_W        = PC_W_DEF,
  parameter int unsigned       STACK_DEPTH = STACK_DEPTH_DEF,
  parameter logic [PC_W-1:0]   ISR1_ADDR   = PC_W'(ISR1_ADDR_DEF),
  parameter logic [PC_W-1:0]   ISR2_ADDR   = PC_W'(ISR2_ADDR_DEF)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_inc,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] jump_addr,
  input  logic            intr1,
  input  logic            intr2,
  output logic [PC_W-1:0] pc,
  output logic            in_isr,
  output logic            stack_full,
  output logic            stack_empty,
  output logic            stack_err
);

  localparam int unsigned SPW = $clog2(STACK_DEPTH) + 1;

  state_t          r_state;
  state_t          w_state_next;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_next;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_norm_next;
  logic [PC_W-1:0] w_vector;
  logic [PC_W-1:0] w_stack_wdata;
  logic [PC_W-1:0] w_top;
  logic [SPW-1:0]  w_sp;
  logic [SPW-1:0]  r_isr_sp;
  logic            r_intr1_d;
  logic            r_intr2_d;
  logic            r_pend1;
  logic            r_pend2;
  logic            r_err;
  logic            w_rise1;
  logic            w_rise2;
  logic            w_full;
  logic            w_empty;
  logic            w_err_ovf;
  logic            w_err_unf;
  logic            w_take1;
  logic            w_take2;
  logic            w_entry;
  logic            w_exit;
  logic            w_st_push;
`ifdef NESTED_INTR_EN
  logic [SPW-1:0]  r_isr_sp1;
  logic            r_isr2_src;
  logic            w_nest_exit;
`endif

  assign w_pc_inc    = r_pc + PC_W'(1);
  assign w_norm_next = s_inc ? w_pc_inc : jump_addr;
  assign w_rise1     = intr1 & ~r_intr1_d;
  assign w_rise2     = intr2 & ~r_intr2_d;

`ifdef NESTED_INTR_EN
  assign w_take1     = r_pend1 & ((r_state == IDLE) | ((r_state == ISR) & r_isr2_src));
  assign w_nest_exit = pop & (r_state == ISR_NEST) & (w_sp == r_isr_sp1 + SPW'(1));
`else
  assign w_take1     = r_pend1 & (r_state == IDLE);
`endif
  assign w_take2  = r_pend2 & ~r_pend1 & (r_state == IDLE);
  assign w_entry  = (w_take1 | w_take2) & ~push & ~pop & ~w_full;
  assign w_vector = w_take1 ? ISR1_ADDR : ISR2_ADDR;
  assign w_exit   = pop & (r_state == ISR) & (w_sp == r_isr_sp + SPW'(1));

  // Interrupt entry reuses the stack write port, saving where the current instruction would go.
  assign w_st_push     = w_entry | push;
  assign w_stack_wdata = w_entry ? w_norm_next : w_pc_inc;

  ret_stack #(
    .DW    (PC_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_st_push),
    .i_pop     (pop),
    .i_wdata   (w_stack_wdata),
    .o_top     (w_top),
    .o_sp      (w_sp),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_err_ovf (w_err_ovf),
    .o_err_unf (w_err_unf)
  );

  always_comb begin
    w_pc_next = w_norm_next;
    if (w_entry) begin
      w_pc_next = w_vector;
    end else if (pop) begin
      w_pc_next = w_empty ? w_pc_inc : w_top;
    end else if (push) begin
      w_pc_next = jump_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc      <= '0;
      r_intr1_d <= 1'b0;
      r_intr2_d <= 1'b0;
      r_pend1   <= 1'b0;
      r_pend2   <= 1'b0;
      r_err     <= 1'b0;
      r_isr_sp  <= '0;
`ifdef NESTED_INTR_EN
      r_isr_sp1  <= '0;
      r_isr2_src <= 1'b0;
`endif
    end else begin
      r_pc      <= w_pc_next;
      r_intr1_d <= intr1;
      r_intr2_d <= intr2;
      r_pend1   <= w_rise1 | (r_pend1 & ~(w_entry & w_take1));
      r_pend2   <= w_rise2 | (r_pend2 & ~(w_entry & w_take2));
      r_err     <= r_err | w_err_ovf | w_err_unf | (push & pop);
      if (w_entry && (r_state == IDLE)) begin
        r_isr_sp <= w_sp;
`ifdef NESTED_INTR_EN
        r_isr2_src <= w_take2;
`endif
      end
`ifdef NESTED_INTR_EN
      if (w_entry && (r_state == ISR)) begin
        r_isr_sp1 <= w_sp;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_entry) w_state_next = ISR;
      end
      ISR: begin
        if (w_exit) begin
          w_state_next = IDLE;
`ifdef NESTED_INTR_EN
        end else if (w_entry) begin
          w_state_next = ISR_NEST;
`endif
        end
      end
      ISR_NEST: begin
`ifdef NESTED_INTR_EN
        if (w_nest_exit) w_state_next = ISR;
`else
        w_state_next = IDLE;
`endif
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    in_isr = (r_state != IDLE);
  end

  assign pc          = r_pc;
  assign stack_full  = w_full;
  assign stack_empty = w_empty;
  assign stack_err   = r_err;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (default and NESTED_INTR_EN builds).
module tb_pc_sequencer;

  logic       clk;
  logic       reset;
  logic       s_inc;
  logic       push;
  logic       pop;
  logic [9:0] jump_addr;
  logic       intr1;
  logic       intr2;
  logic [9:0] pc;
  logic       in_isr;
  logic       stack_full;
  logic       stack_empty;
  logic       stack_err;

  int n_cmp;
  int n_bad;

  pc_sequencer #(
    .PC_W        (10),
    .STACK_DEPTH (16),
    .ISR1_ADDR   (10'h3F0),
    .ISR2_ADDR   (10'h3F8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s_inc       (s_inc),
    .push        (push),
    .pop         (pop),
    .jump_addr   (jump_addr),
    .intr1       (intr1),
    .intr2       (intr2),
    .pc          (pc),
    .in_isr      (in_isr),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .stack_err   (stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; s_inc = 1'b1; push = 1'b0; pop = 1'b0;
    jump_addr = '0; intr1 = 1'b0; intr2 = 1'b0;
    tick(); tick();
    n_cmp++; if (pc !== 10'h000) begin n_bad++; $display("FAIL reset_pc got %h want 000", pc); end
    n_cmp++; if (in_isr !== 1'b0) begin n_bad++; $display("FAIL reset_in_isr got %b want 0", in_isr); end
    n_cmp++; if (stack_empty !== 1'b1 || stack_full !== 1'b0) begin n_bad++; $display("FAIL reset_flags got e=%b f=%b want e=1 f=0", stack_empty, stack_full); end
    n_cmp++; if (stack_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", stack_err); end
    reset = 1'b1;
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_cmp++; if (pc !== 10'(i)) begin n_bad++; $display("FAIL seq_pc got %h want %h", pc, 10'(i)); end
    end
    reset = 1'b0;
    tick();
    n_cmp++; if (pc !== 10'h000) begin n_bad++; $display("FAIL midrun_reset_pc got %h want 000", pc); end
    reset = 1'b1;
  endtask

  task automatic test_call_return();
    s_inc = 1'b0; jump_addr = 10'h010;
    tick();
    n_cmp++; if (pc !== 10'h010) begin n_bad++; $display("FAIL jump_pc got %h want 010", pc); end
    push = 1'b1; jump_addr = 10'h100;
    tick();
    n_cmp++; if (pc !== 10'h100 || stack_empty !== 1'b0) begin n_bad++; $display("FAIL call got pc=%h e=%b want pc=100 e=0", pc, stack_empty); end
    push = 1'b0; pop = 1'b1;
    tick();
    n_cmp++; if (pc !== 10'h011 || stack_empty !== 1'b1) begin n_bad++; $display("FAIL return got pc=%h e=%b want pc=011 e=1", pc, stack_empty); end
    pop = 1'b0; s_inc = 1'b1;
  endtask

  task automatic test_overflow_underflow();
    logic [9:0] exp;
    push = 1'b1;
    for (int k = 0; k < 16; k++) begin
      jump_addr = 10'h200 + 10'(k);
      tick();
      n_cmp++; if (pc !== 10'h200 + 10'(k)) begin n_bad++; $display("FAIL fill_pc got %h want %h", pc, 10'h200 + 10'(k)); end
    end
    n_cmp++; if (stack_full !== 1'b1 || stack_err !== 1'b0) begin n_bad++; $display("FAIL full_flags got f=%b err=%b want f=1 err=0", stack_full, stack_err); end
    jump_addr = 10'h2AA;
    tick();
    n_cmp++; if (pc !== 10'h2AA || stack_full !== 1'b1 || stack_err !== 1'b1) begin n_bad++; $display("FAIL overflow got pc=%h f=%b err=%b want pc=2aa f=1 err=1", pc, stack_full, stack_err); end
    push = 1'b0; pop = 1'b1;
    for (int j = 0; j < 16; j++) begin
      exp = (j < 15) ? (10'h20F - 10'(j)) : 10'h012;
      tick();
      n_cmp++; if (pc !== exp) begin n_bad++; $display("FAIL drain_pc got %h want %h", pc, exp); end
    end
    n_cmp++; if (stack_empty !== 1'b1) begin n_bad++; $display("FAIL drain_empty got %b want 1", stack_empty); end
    tick();
    n_cmp++; if (pc !== 10'h013 || stack_err !== 1'b1) begin n_bad++; $display("FAIL underflow got pc=%h err=%b want pc=013 err=1", pc, stack_err); end
    pop = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_cmp++; if (stack_err !== 1'b0 || pc !== 10'h000) begin n_bad++; $display("FAIL err_clear got err=%b pc=%h want err=0 pc=000", stack_err, pc); end
  endtask

  task automatic test_isr_entry_exit();
    s_inc = 1'b0; jump_addr = 10'h01F;
    tick();
    s_inc = 1'b1; intr2 = 1'b1;
    tick();
    n_cmp++; if (pc !== 10'h020 || in_isr !== 1'b0) begin n_bad++; $display("FAIL pre_isr got pc=%h isr=%b want pc=020 isr=0", pc, in_isr); end
    tick();
    n_cmp++; if (pc !== 10'h3F8 || in_isr !== 1'b1) begin n_bad++; $display("FAIL isr2_entry got pc=%h isr=%b want pc=3f8 isr=1", pc, in_isr); end
    push = 1'b1; jump_addr = 10'h300;
    tick();
    n_cmp++; if (pc !== 10'h300 || in_isr !== 1'b1) begin n_bad++; $display("FAIL isr_call got pc=%h isr=%b want pc=300 isr=1", pc, in_isr); end
    push = 1'b0; pop = 1'b1;
    tick();
    n_cmp++; if (pc !== 10'h3F9 || in_isr !== 1'b1) begin n_bad++; $display("FAIL isr_inner_ret got pc=%h isr=%b want pc=3f9 isr=1", pc, in_isr); end
    tick();
    n_cmp++; if (pc !== 10'h021 || in_isr !== 1'b0 || stack_empty !== 1'b1) begin n_bad++; $display("FAIL isr_exit got pc=%h isr=%b e=%b want pc=021 isr=0 e=1", pc, in_isr, stack_empty); end
    pop = 1'b0; intr2 = 1'b0;
    tick();
  endtask

  task automatic test_dual_intr_deferred();
    intr1 = 1'b1; intr2 = 1'b1;
    tick();
    n_cmp++; if (pc !== 10'h023) begin n_bad++; $display("FAIL dual_latch_pc got %h want 023", pc); end
    push = 1'b1; jump_addr = 10'h150;
    tick();
    n_cmp++; if (pc !== 10'h150 || in_isr !== 1'b0) begin n_bad++; $display("FAIL deferred got pc=%h isr=%b want pc=150 isr=0", pc, in_isr); end
    push = 1'b0;
    tick();
    n_cmp++; if (pc !== 10'h3F0 || in_isr !== 1'b1) begin n_bad++; $display("FAIL isr1_first got pc=%h isr=%b want pc=3f0 isr=1", pc, in_isr); end
    pop = 1'b1;
    tick();
    n_cmp++; if (pc !== 10'h151 || in_isr !== 1'b0) begin n_bad++; $display("FAIL isr1_exit got pc=%h isr=%b want pc=151 isr=0", pc, in_isr); end
    pop = 1'b0;
    tick();
    n_cmp++; if (pc !== 10'h3F8 || in_isr !== 1'b1) begin n_bad++; $display("FAIL isr2_second got pc=%h isr=%b want pc=3f8 isr=1", pc, in_isr); end
  endtask

  task automatic test_intr1_during_isr2();
    intr1 = 1'b0;
    tick();
    intr1 = 1'b1;
    tick();
    n_cmp++; if (pc !== 10'h3FA) begin n_bad++; $display("FAIL isr2_run got pc=%h want 3fa", pc); end
    tick();
`ifdef NESTED_INTR_EN
    n_cmp++; if (pc !== 10'h3F0 || in_isr !== 1'b1) begin n_bad++; $display("FAIL nest_entry got pc=%h isr=%b want pc=3f0 isr=1", pc, in_isr); end
    pop = 1'b1;
    tick();
    n_cmp++; if (pc !== 10'h3FB || in_isr !== 1'b1) begin n_bad++; $display("FAIL nest_return got pc=%h isr=%b want pc=3fb isr=1", pc, in_isr); end
    tick();
    n_cmp++; if (pc !== 10'h152 || in_isr !== 1'b0) begin n_bad++; $display("FAIL isr2_exit got pc=%h isr=%b want pc=152 isr=0", pc, in_isr); end
    pop = 1'b0;
`else
    n_cmp++; if (pc !== 10'h3FB || in_isr !== 1'b1) begin n_bad++; $display("FAIL no_preempt got pc=%h isr=%b want pc=3fb isr=1", pc, in_isr); end
    pop = 1'b1;
    tick();
    n_cmp++; if (pc !== 10'h152 || in_isr !== 1'b0) begin n_bad++; $display("FAIL isr2_exit got pc=%h isr=%b want pc=152 isr=0", pc, in_isr); end
    pop = 1'b0;
    tick();
    n_cmp++; if (pc !== 10'h3F0 || in_isr !== 1'b1) begin n_bad++; $display("FAIL isr1_after got pc=%h isr=%b want pc=3f0 isr=1", pc, in_isr); end
    pop = 1'b1;
    tick();
    n_cmp++; if (pc !== 10'h153 || in_isr !== 1'b0) begin n_bad++; $display("FAIL isr1_exit got pc=%h isr=%b want pc=153 isr=0", pc, in_isr); end
    pop = 1'b0;
`endif
  endtask

  task automatic test_push_pop_conflict();
    intr1 = 1'b0; intr2 = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    push = 1'b1; jump_addr = 10'h080;
    tick();
    n_cmp++; if (pc !== 10'h080) begin n_bad++; $display("FAIL conflict_call got pc=%h want 080", pc); end
    pop = 1'b1;
    tick();
    n_cmp++; if (pc !== 10'h001 || stack_err !== 1'b1 || stack_empty !== 1'b1) begin n_bad++; $display("FAIL conflict got pc=%h err=%b e=%b want pc=001 err=1 e=1", pc, stack_err, stack_empty); end
    push = 1'b0; pop = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_sequential();
    test_call_return();
    test_overflow_underflow();
    test_isr_entry_exit();
    test_dual_intr_deferred();
    test_intr1_during_isr2();
    test_push_pop_conflict();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter and return-stack stage placed directly downstream of the single-cycle CPU control unit.
- Consumes the control unit's s_inc, push and pop strobes, plus the jump target field of the current instruction. Produces the program-memory address.
- Owns the return-address LIFO and interrupt entry/exit. intr1 and intr2 are edge-latched and vectored to fixed ISR addresses.

Parameters:
- PC_W, 10, program counter / program memory address width
- STACK_DEPTH, 16, return-stack entries (power of two, ≥2)
- ISR1_ADDR, 10'h3F0, vector for intr1 (highest priority)
- ISR2_ADDR, 10'h3F8, vector for intr2

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- s_inc  in  1  1: sequential (pc+1); 0: take jump_addr
- push  in  1  call: save return address, branch to jump_addr
- pop  in  1  return: reload pc from stack top
- jump_addr  in  PC_W  jump/call target from instruction word
- intr1  in  1  interrupt request 1, level, asynchronous to instruction flow
- intr2  in  1  interrupt request 2
- pc  out  PC_W  current program-memory address
- in_isr  out  1  executing inside an interrupt service routine
- stack_full  out  1  sp == STACK_DEPTH
- stack_empty  out  1  sp == 0
- stack_err  out  1  sticky overflow/underflow flag

Behaviour:
- Reset (reset=0 at clk edge): pc=0, sp=0, in_isr=0, stack_err=0, pending flags=0, intr edge registers=0, state=IDLE. Stack contents undefined. Reset mid-ISR aborts it cleanly.
- Latency: every next-pc decision is registered. pc changes one clock after the inputs are sampled. No stall cycles.
- Next-pc priority, highest first:
  - interrupt entry
  - pop
  - push
  - s_inc ? pc+1 : jump_addr
- pc+1 wraps modulo 2^PC_W.
- push (call): stack[sp] <= pc+1, sp <= sp+1, pc <= jump_addr. s_inc is ignored.
- pop (return): pc <= stack[sp-1], sp <= sp-1.
- push and pop both asserted: pop wins. stack_err is set; sp is unchanged by the push.
- Overflow: push while stack_full → no write, sp holds, pc <= jump_addr, stack_err <= 1.
- Underflow: pop while stack_empty → sp holds, pc <= pc+1, stack_err <= 1.
- stack_err clears only on reset.
- Interrupt capture:
  - Rising edge of intrN (registered previous value) sets pendN.
  - pendN is cleared only on entry to that ISR.
  - An edge coinciding with entry to that ISR sets pendN again.
- Entry conditions, all required:
  - state=IDLE
  - a pending flag set
  - push=0 and pop=0 this cycle (otherwise entry is deferred one cycle)
  - !stack_full (otherwise deferred; no error)
- Entry action:
  - stack[sp] <= normal next pc of the current instruction (the instruction completes).
  - sp++, pc <= vector.
  - pend1 takes priority over pend2.
  - state=ISR, in_isr=1, isr_sp <= sp (the value before the increment).
- Exit: pop with state=ISR and sp==isr_sp+1 → normal pop, plus state=IDLE, in_isr=0.
- Nested calls inside an ISR push/pop normally and do not exit.
- States: IDLE, ISR. With NESTED_INTR_EN, a third state ISR_NEST is added.

Optional Feature:
- Macro: NESTED_INTR_EN.
- Defined: while in ISR entered from intr2, a pending intr1 preempts it.
  - Entry follows the same rules; state goes to ISR_NEST.
  - Second saved level isr_sp1 is recorded.
  - Return from ISR_NEST (sp==isr_sp1+1) → state ISR.
  - intr2 never preempts and intr1 never nests on itself.
- Undefined: no entry while in_isr=1. Requests stay pending until exit.

Decomposition:
- Package pc_seq_pkg holds:
  - state typedef (IDLE, ISR, ISR_NEST)
  - default vector constants
  - PC_W default
- Sub-module ret_stack: synchronous-write LIFO with asynchronous read of top, sp counter, full/empty flags, err_ovf/err_unf outputs.
- pc_sequencer contains next-pc mux, edge detection, pending flags and the FSM.

Test Plan:
- Reset then 5 cycles of s_inc=1 → pc 0,1,2,3,4,5. Hold reset=0 one cycle mid-run → pc=0 on the next edge.
- At pc=0x010: push=1, jump_addr=0x100 → pc=0x100, sp=1. Then pop → pc=0x011, sp=0, stack_empty=1.
- Push 16 times (stack_full=1), then a 17th push → pc=jump_addr, sp=16, stack_err=1. Pop at sp=0 → pc=pc+1, stack_err stays 1.
- intr2 rising edge at pc=0x020, s_inc=1 → next pc=ISR2_ADDR, in_isr=1, stack top=0x021. A nested call/return inside the ISR keeps in_isr=1. The ISR's final pop → pc=0x021, in_isr=0.
- intr1 and intr2 rise on the same cycle while a push is active → entry deferred one cycle, then pc=ISR1_ADDR. After its return → ISR2_ADDR is entered next.
- NESTED_INTR_EN: intr1 during ISR2 → pc=ISR1_ADDR, state ISR_NEST. Return → back inside ISR2 with in_isr=1. Without the macro: intr1 is taken only after ISR2 exits.
